// File: rtl/psram_sched_pkg.sv
// Shared types and constants for the PSRAM burst scheduler.
package psram_sched_pkg;

    localparam int unsigned ADDR_W = 23;

    localparam logic [ADDR_W-1:0] BUF0_BASE = '0;

    typedef enum logic [1:0] {
        S_WAIT_CFG,
        S_IDLE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } sched_state_t;

    // True when a burst starting at ptr is the last one of a frame.
    function automatic logic last_burst(input logic [ADDR_W-1:0] ptr,
                                        input logic [ADDR_W-1:0] len,
                                        input logic [ADDR_W-1:0] frame);
        return (ptr + len) == frame;
    endfunction

endpackage

// File: rtl/psram_sync2.sv
// Two-flop synchroniser for the controller's done flag (clk160 -> clk100).
// Resets to 1 so the scheduler sees an idle controller out of reset.
module psram_sync2 (
    input  logic clk100_i,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops.
    always_ff @(posedge clk100_i or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/psram_burst_sched.sv
// PSRAM burst scheduler: picks write (camera) or read (display) bursts,
// hands one at a time to the burst controller and keeps frame pointers.
// Optional build macro: DOUBLE_BUFFER_EN (ping-pong frame buffers).
module psram_burst_sched
    import psram_sched_pkg::*;
#(
    parameter int unsigned       BURST_LEN   = 32,
    parameter int unsigned       FRAME_WORDS = 307200,
    parameter logic [ADDR_W-1:0] BUF1_BASE   = 23'h100000,
    parameter int unsigned       CNT_W       = 10,
    parameter int unsigned       ACK_TMO     = 64
) (
    input  logic              clk100_i,
    input  logic              rst,
    input  logic              cfg_done_i,
    input  logic              frame_start_i,
    input  logic              rd_en_i,
    input  logic [CNT_W-1:0]  wr_fifo_cnt_i,
    input  logic [CNT_W-1:0]  rd_fifo_free_i,
    input  logic              brst_done_i,
    output logic              brst_go_o,
    output logic              brst_wr_o,
    output logic [ADDR_W-1:0] brst_addr_o,
    output logic              frame_wr_done_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_A   = ADDR_W'(FRAME_WORDS);
    localparam int unsigned       TMO_W     = $clog2(ACK_TMO + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACK_TMO - 1);

    sched_state_t      state_q, state_nx;
    logic              done_s;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_eff;
    logic [ADDR_W-1:0] wr_base, rd_base;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              wr_buf;
    logic              fs_pend, fs_hit;
    logic              wr_req, rd_req;
    logic              issue, issue_wr, ack_tmo, complete;

    psram_sync2 u_done_sync (
        .clk100_i (clk100_i),
        .rst      (rst),
        .d        (brst_done_i),
        .q        (done_s)
    );

    assign wr_req = wr_fifo_cnt_i >= BURST_CNT;
    assign rd_req = rd_en_i && (rd_fifo_free_i >= BURST_CNT);
    assign busy_o = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);

    // A frame start seen while idle takes effect on the burst issued this cycle.
    assign wr_ptr_eff = frame_start_i ? '0 : wr_ptr;
    // Pending restart, including one arriving in the completion cycle itself.
    assign fs_hit     = fs_pend || frame_start_i;

`ifdef DOUBLE_BUFFER_EN
    assign rd_base = wr_buf ? BUF0_BASE : BUF1_BASE;
`else
    assign wr_buf  = 1'b0;
    assign rd_base = BUF0_BASE;
`endif
    assign wr_base = wr_buf ? BUF1_BASE : BUF0_BASE;

    // State register.
    always_ff @(posedge clk100_i or posedge rst) begin
        if (rst) state_q <= S_WAIT_CFG;
        else     state_q <= state_nx;
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nx = state_q;
        issue    = 1'b0;
        issue_wr = 1'b0;
        ack_tmo  = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_WAIT_CFG: begin
                if (cfg_done_i && done_s) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (wr_req) begin
                    issue    = 1'b1;
                    issue_wr = 1'b1;
                    state_nx = S_WAIT_ACK;
                end else if (rd_req) begin
                    issue    = 1'b1;
                    state_nx = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!done_s) begin
                    state_nx = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    ack_tmo  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (done_s) begin
                    complete = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_WAIT_CFG;
        endcase
    end

    // Burst request registers, frame pointers, buffer select and status flags.
    always_ff @(posedge clk100_i or posedge rst) begin
        if (rst) begin
            brst_go_o       <= 1'b0;
            brst_wr_o       <= 1'b0;
            brst_addr_o     <= '0;
            frame_wr_done_o <= 1'b0;
            err_o           <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            tmo_cnt         <= '0;
            fs_pend         <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
            wr_buf          <= 1'b0;
`endif
        end else begin
            brst_go_o       <= issue;
            frame_wr_done_o <= 1'b0;

            if (issue)                     tmo_cnt <= '0;
            else if (state_q == S_WAIT_ACK) tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (issue) begin
                brst_wr_o   <= issue_wr;
                brst_addr_o <= issue_wr ? (wr_base + wr_ptr_eff) : (rd_base + rd_ptr);
            end

            if (frame_start_i && (state_q == S_IDLE || state_q == S_WAIT_CFG))
                wr_ptr <= '0;
            if (frame_start_i && busy_o)
                fs_pend <= 1'b1;

            if (ack_tmo)
                err_o <= 1'b1;

            // A restart pending at completion (or timeout) replaces the write
            // advance, so it also suppresses the frame-done pulse and swap.
            if (complete || ack_tmo) begin
                fs_pend <= 1'b0;
                if (fs_hit) wr_ptr <= '0;
            end

            if (complete) begin
                if (brst_wr_o) begin
                    if (!fs_hit) begin
                        if (last_burst(wr_ptr, BURST_A, FRAME_A)) begin
                            wr_ptr          <= '0;
                            frame_wr_done_o <= 1'b1;
`ifdef DOUBLE_BUFFER_EN
                            wr_buf          <= ~wr_buf;
                            rd_ptr          <= '0;
`endif
                        end else begin
                            wr_ptr <= wr_ptr + BURST_A;
                        end
                    end
                end else begin
                    rd_ptr <= last_burst(rd_ptr, BURST_A, FRAME_A) ? '0 : (rd_ptr + BURST_A);
                end
            end
        end
    end

endmodule
